// File: rtl/frog_collision.sv
// Frog/car collision scanner.
// On a start request the frog position is latched and the cars of the frog's
// lane are scanned one per cycle through an external car-position mux
// (sel_lane/sel_car -> car_x/car_len). The OR of all overlaps is reported
// with a one-cycle done pulse; hit_count saturates at 15.
// Optional build macro: FROG_COLLISION_MARGIN_EN shrinks the frog hitbox by
// HIT_MARGIN pixels on each side.
module frog_collision #(
    parameter int unsigned BLOCKSIZE     = 32,
    parameter int unsigned CARS_PER_LANE = 3,
    parameter int unsigned HIT_MARGIN    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] frog_x,
    input  logic [2:0] frog_lane,
    output logic [2:0] sel_lane,
    output logic [1:0] sel_car,
    input  logic [9:0] car_x,
    input  logic [9:0] car_len,
    output logic       busy,
    output logic       done,
    output logic       hit,
    output logic [3:0] hit_count
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

`ifdef FROG_COLLISION_MARGIN_EN
    localparam logic [10:0] LP_FL_OFS = 11'(HIT_MARGIN);
    localparam logic [10:0] LP_FW     = 11'(BLOCKSIZE - 2 * HIT_MARGIN);
`else
    localparam logic [10:0] LP_FL_OFS = 11'd0;
    localparam logic [10:0] LP_FW     = 11'(BLOCKSIZE);
`endif
    localparam logic [1:0] LP_LAST_CAR = 2'(CARS_PER_LANE - 1);
    localparam logic [2:0] LP_LAST_ROAD_LANE = 3'd5;

    state_t     r_state, w_state_d;
    logic [9:0] r_frog_x, w_frog_x_d;
    logic [2:0] r_sel_lane, w_sel_lane_d;
    logic [1:0] r_sel_car, w_sel_car_d;
    logic       r_hit_acc, w_hit_acc_d;
    logic       r_hit, w_hit_d;
    logic       r_done, w_done_d;
    logic [3:0] r_hit_count, w_hit_count_d;

    // Hitbox and car extents, widened to 11 bits so right edges never wrap
    logic [10:0] w_fl, w_fr, w_car_l, w_car_r;
    logic        w_overlap;
    logic        w_acc_now;

    // Overlap of the latched frog hitbox with the currently selected car
    always_comb begin
        w_fl      = {1'b0, r_frog_x} + LP_FL_OFS;
        w_fr      = w_fl + LP_FW;
        w_car_l   = {1'b0, car_x};
        w_car_r   = w_car_l + {1'b0, car_len};
        // Strict compares: touching edges do not collide; zero-length cars never hit
        w_overlap = (car_len != 10'd0) && (w_car_l < w_fr) && (w_fl < w_car_r);
        w_acc_now = r_hit_acc | w_overlap;
    end

    // Next-state and datapath updates for the scan FSM
    always_comb begin
        w_state_d     = r_state;
        w_frog_x_d    = r_frog_x;
        w_sel_lane_d  = r_sel_lane;
        w_sel_car_d   = r_sel_car;
        w_hit_acc_d   = r_hit_acc;
        w_hit_d       = r_hit;
        w_done_d      = 1'b0;
        w_hit_count_d = r_hit_count;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_frog_x_d   = frog_x;
                    w_sel_lane_d = frog_lane;
                    w_sel_car_d  = 2'd0;
                    w_hit_acc_d  = 1'b0;
                    if (frog_lane <= LP_LAST_ROAD_LANE) begin
                        w_state_d = SCAN;
                    end else begin
                        // Off-road: nothing to scan, report a miss right away
                        w_state_d = REPORT;
                        w_hit_d   = 1'b0;
                        w_done_d  = 1'b1;
                    end
                end
            end
            SCAN: begin
                w_hit_acc_d = w_acc_now;
                if (r_sel_car == LP_LAST_CAR) begin
                    w_state_d   = REPORT;
                    w_sel_car_d = 2'd0;
                    w_hit_d     = w_acc_now;
                    w_done_d    = 1'b1;
                    if (w_acc_now && (r_hit_count != 4'd15)) begin
                        w_hit_count_d = r_hit_count + 4'd1;
                    end
                end else begin
                    w_sel_car_d = r_sel_car + 2'd1;
                end
            end
            REPORT: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any scan in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_frog_x    <= 10'd0;
            r_sel_lane  <= 3'd0;
            r_sel_car   <= 2'd0;
            r_hit_acc   <= 1'b0;
            r_hit       <= 1'b0;
            r_done      <= 1'b0;
            r_hit_count <= 4'd0;
        end else begin
            r_state     <= w_state_d;
            r_frog_x    <= w_frog_x_d;
            r_sel_lane  <= w_sel_lane_d;
            r_sel_car   <= w_sel_car_d;
            r_hit_acc   <= w_hit_acc_d;
            r_hit       <= w_hit_d;
            r_done      <= w_done_d;
            r_hit_count <= w_hit_count_d;
        end
    end

    assign sel_lane  = r_sel_lane;
    assign sel_car   = r_sel_car;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign hit       = r_hit;
    assign hit_count = r_hit_count;

endmodule

// File: tb/tb_frog_collision.sv
// Self-checking bench for frog_collision: directed cases plus randomized
// traffic, checked every cycle against a behavioural scan model.
module tb_frog_collision;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] frog_x;
    logic [2:0] frog_lane;
    logic [2:0] sel_lane;
    logic [1:0] sel_car;
    logic [9:0] car_x;
    logic [9:0] car_len;
    logic       busy;
    logic       done;
    logic       hit;
    logic [3:0] hit_count;

    // Car table indexed [lane][car]; the DUT reads it through sel_lane/sel_car
    logic [9:0] t_x   [8][4];
    logic [9:0] t_len [8][4];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: remaining busy cycles, pending result, visible outputs
    int m_left = 0;
    bit m_pend = 0;
    bit m_done = 0;
    bit m_hit  = 0;
    int m_cnt  = 0;
    int m_lane = 0;

`ifdef FROG_COLLISION_MARGIN_EN
    localparam int EXP_HIT_033 = 0;
`else
    localparam int EXP_HIT_033 = 1;
`endif
    localparam int EXP_CNT_033 = 1 + EXP_HIT_033;

    frog_collision dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .frog_x    (frog_x),
        .frog_lane (frog_lane),
        .sel_lane  (sel_lane),
        .sel_car   (sel_car),
        .car_x     (car_x),
        .car_len   (car_len),
        .busy      (busy),
        .done      (done),
        .hit       (hit),
        .hit_count (hit_count)
    );

    always #5 clk = ~clk;

    assign car_x   = t_x[sel_lane][sel_car];
    assign car_len = t_len[sel_lane][sel_car];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Does the frog at fx in lane ln touch any car of that lane (interior overlap)?
    function automatic bit model_hit(input int fx, input int ln);
        int fl;
        int fw;
`ifdef FROG_COLLISION_MARGIN_EN
        fl = fx + 4;
        fw = 32 - 2 * 4;
`else
        fl = fx;
        fw = 32;
`endif
        if (ln > 5) return 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (t_len[ln][c] != 0 && int'(t_x[ln][c]) < fl + fw &&
                fl < int'(t_x[ln][c]) + int'(t_len[ln][c])) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Model: an accepted request keeps the block busy for 4 cycles on road,
    // 1 cycle off road; the result appears with done in the last busy cycle.
    always @(posedge clk or posedge reset) begin : model
        int nl;
        bit p;
        if (reset) begin
            m_left <= 0;
            m_done <= 0;
            m_hit  <= 0;
            m_cnt  <= 0;
            m_lane <= 0;
        end else begin
            p = m_pend;
            if (m_left > 0) begin
                nl = m_left - 1;
            end else if (start) begin
                nl = (int'(frog_lane) <= 5) ? 4 : 1;
                p  = model_hit(int'(frog_x), int'(frog_lane));
                m_lane <= int'(frog_lane);
            end else begin
                nl = 0;
            end
            m_pend <= p;
            m_left <= nl;
            m_done <= (nl == 1);
            if (nl == 1) begin
                m_hit <= p;
                if (p && m_cnt < 15) m_cnt <= m_cnt + 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_left > 0));
        chk("done", int'(done), int'(m_done));
        chk("hit", int'(hit), int'(m_hit));
        chk("hit_count", int'(hit_count), m_cnt);
        if (m_left > 0) chk("sel_lane", int'(sel_lane), m_lane);
    end

    // Issue one start and return the done latency in cycles (-1 if none within 10)
    task automatic run_scan(input int fx, input int ln, output int lat);
        frog_x    = 10'(fx);
        frog_lane = 3'(ln);
        start     = 1'b1;
        lat       = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #2;
            start = 1'b0;
            @(negedge clk);
            if (done && lat < 0) lat = k;
        end
    endtask

    task automatic rand_table(input int fx);
        int x;
        for (int l = 0; l < 6; l++) begin
            for (int c = 0; c < 3; c++) begin
                x = fx + int'($urandom_range(0, 100)) - 50;
                if (x < 0) x = 0;
                if (x > 1023) x = 1023;
                if ($urandom_range(0, 3) == 0) x = int'($urandom_range(0, 1023));
                t_x[l][c]   = 10'(x);
                t_len[l][c] = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 60));
            end
        end
    endtask

    initial begin
        int  lat;
        bit  saw;
        int  fx;
        reset     = 1'b0;
        start     = 1'b0;
        frog_x    = 10'd0;
        frog_lane = 3'd0;
        for (int l = 0; l < 8; l++) begin
            for (int c = 0; c < 4; c++) begin
                t_x[l][c]   = 10'd900;
                t_len[l][c] = 10'd0;
            end
        end
        t_x[0][0] = 10'd96;  t_len[0][0] = 10'd32;
        t_x[0][1] = 10'd250; t_len[0][1] = 10'd32;
        t_x[0][2] = 10'd400; t_len[0][2] = 10'd32;

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_hit_count", int'(hit_count), 0);
        chk("rst_sel_lane", int'(sel_lane), 0);
        chk("rst_sel_car", int'(sel_car), 0);
        chk("model_pin_hit", int'(model_hit(96, 0)), 1);
        chk("model_pin_touch", int'(model_hit(128, 0)), 0);

        // Frog directly on car0
        @(posedge clk); #2;
        run_scan(96, 0, lat);
        chk("lat_onroad", lat, 4);
        chk("hit_031", int'(hit), 1);
        chk("cnt_031", int'(hit_count), 1);

        // Touching car0's right edge only
        @(posedge clk); #2;
        run_scan(128, 0, lat);
        chk("lat_032", lat, 4);
        chk("hit_032", int'(hit), 0);
        chk("cnt_032", int'(hit_count), 1);

        // 4-pixel overlap: hit only with the full hitbox
        @(posedge clk); #2;
        run_scan(124, 0, lat);
        chk("hit_033", int'(hit), EXP_HIT_033);
        chk("cnt_033", int'(hit_count), EXP_CNT_033);

        // Off road
        @(posedge clk); #2;
        run_scan(96, 6, lat);
        chk("lat_offroad", lat, 1);
        chk("hit_034", int'(hit), 0);
        chk("sel_car_034", int'(sel_car), 0);
        chk("cnt_034", int'(hit_count), EXP_CNT_033);

        // Start during scan ignored, then reset in the 2nd scan cycle
        @(posedge clk); #2;
        frog_x = 10'd96; frog_lane = 3'd0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b1; frog_lane = 3'd6; frog_x = 10'd500;
        @(posedge clk); #2;
        start = 1'b0;
        chk("busy_scan2", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("busy_reset", int'(busy), 0);
        @(negedge clk);
        chk("hit_reset", int'(hit), 0);
        chk("cnt_reset", int'(hit_count), 0);
        @(posedge clk); #2;
        reset = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        chk("no_done_after_reset", int'(saw), 0);

        // First scan after reset, then saturation
        @(posedge clk); #2;
        run_scan(96, 0, lat);
        chk("lat_after_reset", lat, 4);
        chk("hit_after_reset", int'(hit), 1);
        chk("cnt_after_reset", int'(hit_count), 1);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #2;
            run_scan(100, 0, lat);
        end
        chk("cnt_saturated", int'(hit_count), 15);
        @(posedge clk); #2;
        run_scan(96, 0, lat);
        chk("cnt_stays_15", int'(hit_count), 15);

        // Randomized traffic, checked by the per-cycle compare
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #2;
            start = 1'b0;
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
            end else if (m_left == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    fx = int'($urandom_range(0, 1023));
                    rand_table(fx);
                    frog_x    = 10'(fx);
                    frog_lane = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(6, 7))
                                                            : 3'($urandom_range(0, 5));
                    start     = 1'b1;
                end
            end else begin
                frog_x    = 10'($urandom_range(0, 1023));
                frog_lane = 3'($urandom_range(0, 7));
                start     = 1'($urandom_range(0, 1));
            end
        end

        @(posedge clk); #2;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
